// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types, constants and edge-select helper for the SPI slave
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_RESET_VALUE = 32'h4A23_0010;

    // Modes 0 and 3 sample on the rising sck edge, modes 1 and 2 on the falling edge.
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return ~(cpol ^ cpha);
    endfunction

endpackage

// File: rtl/spi_slave_duplex_if.sv
// rtl/spi_slave_duplex_if.sv - pin and word-side signals of the SPI slave
// Pins: cs_n, sck, mosi (in), miso, miso_oe (out).
// Word side: tx_data (in), rx_data, rx_valid, frame_err (out).
interface spi_slave_duplex_if #(
    parameter int BITS = 32
);
    logic            cs_n;
    logic            sck;
    logic            mosi;
    logic            miso;
    logic            miso_oe;
    logic [BITS-1:0] tx_data;
    logic [BITS-1:0] rx_data;
    logic            rx_valid;
    logic            frame_err;

    modport slave (
        input  cs_n, sck, mosi, tx_data,
        output miso, miso_oe, rx_data, rx_valid, frame_err
    );

    modport master (
        output cs_n, sck, mosi, tx_data,
        input  miso, miso_oe, rx_data, rx_valid, frame_err
    );
endinterface

// File: rtl/spi_slave_duplex_pin_sync.sv
// rtl/spi_slave_duplex_pin_sync.sv - two-flop pin synchroniser with edge detect
// Ports: clk, reset (sync, active-high), i_pin (async pin),
//        o_sync (synchronised level), o_rise / o_fall (one-cycle edge strobes).
module spi_pin_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    // All stages reset to the pin's idle level so no false edge follows reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;
endmodule

// File: rtl/spi_slave_duplex.sv
// rtl/spi_slave_duplex.sv - full-duplex SPI slave, all four modes, with abort and timeout
// Ports: clk, reset (sync, active-high), bus (slave modport):
//        cs_n/sck/mosi pins in, miso/miso_oe out, tx_data word in,
//        rx_data word out, rx_valid and frame_err one-cycle strobes out.
module spi_slave_duplex
    import spi_pkg::*;
#(
    parameter int          BITS        = 32,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter int          TIMEOUT     = 1024,
    parameter logic [31:0] RESET_VALUE = DEFAULT_RESET_VALUE
) (
    input logic              clk,
    input logic              reset,
    spi_slave_duplex_if.slave bus
);
    localparam int              BCW         = $clog2(BITS + 1);
    localparam int              TCW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [BITS-1:0] RST_WORD    = BITS'(RESET_VALUE);
    localparam bit              SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
    localparam logic [BCW-1:0]  LAST_BIT    = BCW'(BITS - 1);
    localparam logic [TCW-1:0]  TO_LIMIT    = TCW'(TIMEOUT);

    logic w_cs_sync, w_cs_rise, w_cs_fall;
    logic w_sck_rise, w_sck_fall;
    logic w_mosi_sync;
    logic w_sample, w_shift;

    spi_pin_sync #(.RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .reset(reset), .i_pin(bus.cs_n),
        .o_sync(w_cs_sync), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );
    spi_pin_sync #(.RST_VAL(CPOL)) u_sck_sync (
        .clk(clk), .reset(reset), .i_pin(bus.sck),
        .o_sync(), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );
    spi_pin_sync #(.RST_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .reset(reset), .i_pin(bus.mosi),
        .o_sync(w_mosi_sync), .o_rise(), .o_fall()
    );

    assign w_sample = SAMPLE_RISE ? w_sck_rise : w_sck_fall;
    assign w_shift  = SAMPLE_RISE ? w_sck_fall : w_sck_rise;

    state_t          r_state, w_nx_state;
    logic [BCW-1:0]  r_bit_cnt, w_nx_bit_cnt;
    logic [TCW-1:0]  r_to_cnt, w_nx_to_cnt;
    logic [BITS-1:0] r_tx_sr, w_nx_tx_sr;
    logic [BITS-1:0] r_rx_sr, w_nx_rx_sr;
    logic [BITS-1:0] r_rx_data, w_nx_rx_data;
    logic            r_rx_valid, w_nx_rx_valid;
    logic            r_frame_err, w_nx_frame_err;
    logic            r_skip, w_nx_skip;
    logic [BITS-1:0] w_rx_shifted;

    assign w_rx_shifted = {r_rx_sr[BITS-2:0], w_mosi_sync};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_to_cnt    <= '0;
            r_tx_sr     <= '0;
            r_rx_sr     <= '0;
            r_rx_data   <= RST_WORD;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_skip      <= 1'b0;
        end else begin
            r_state     <= w_nx_state;
            r_bit_cnt   <= w_nx_bit_cnt;
            r_to_cnt    <= w_nx_to_cnt;
            r_tx_sr     <= w_nx_tx_sr;
            r_rx_sr     <= w_nx_rx_sr;
            r_rx_data   <= w_nx_rx_data;
            r_rx_valid  <= w_nx_rx_valid;
            r_frame_err <= w_nx_frame_err;
            r_skip      <= w_nx_skip;
        end
    end

    // r_skip suppresses the one shift edge that would otherwise push out a freshly
    // loaded MSB: the first leading edge in CPHA=1, and the trailing edge right
    // after a frame-completing sample in CPHA=0.
    always_comb begin
        w_nx_state     = r_state;
        w_nx_bit_cnt   = r_bit_cnt;
        w_nx_to_cnt    = r_to_cnt;
        w_nx_tx_sr     = r_tx_sr;
        w_nx_rx_sr     = r_rx_sr;
        w_nx_rx_data   = r_rx_data;
        w_nx_rx_valid  = 1'b0;
        w_nx_frame_err = 1'b0;
        w_nx_skip      = r_skip;
        case (r_state)
            IDLE: begin
                w_nx_bit_cnt = '0;
                w_nx_to_cnt  = '0;
                if (w_cs_fall) begin
                    w_nx_tx_sr = bus.tx_data;
                    w_nx_skip  = CPHA;
                    w_nx_state = SHIFT;
                end
            end
            SHIFT: begin
                if (w_cs_rise) begin
                    // Deselect beats any coincident sck edge.
                    w_nx_frame_err = (r_bit_cnt != '0);
                    w_nx_bit_cnt   = '0;
                    w_nx_to_cnt    = '0;
                    w_nx_state     = IDLE;
                end else if (TIMEOUT != 0 && r_bit_cnt != '0 && r_to_cnt == TO_LIMIT) begin
                    w_nx_frame_err = 1'b1;
                    w_nx_bit_cnt   = '0;
                    w_nx_to_cnt    = '0;
                    w_nx_state     = STALL;
                end else begin
                    if (r_bit_cnt != '0 && r_to_cnt != TO_LIMIT) begin
                        w_nx_to_cnt = r_to_cnt + 1'b1;
                    end
                    if (w_sample) begin
                        w_nx_to_cnt = '0;
                        w_nx_rx_sr  = w_rx_shifted;
                        if (r_bit_cnt == LAST_BIT) begin
                            w_nx_rx_data  = w_rx_shifted;
                            w_nx_rx_valid = 1'b1;
                            w_nx_bit_cnt  = '0;
                            w_nx_tx_sr    = bus.tx_data;
                            w_nx_skip     = 1'b1;
                        end else begin
                            w_nx_bit_cnt = r_bit_cnt + 1'b1;
                        end
                    end else if (w_shift) begin
                        if (r_skip) begin
                            w_nx_skip = 1'b0;
                        end else begin
                            w_nx_tx_sr = r_tx_sr << 1;
                        end
                    end
                end
            end
            STALL: begin
                w_nx_bit_cnt = '0;
                w_nx_to_cnt  = '0;
                if (w_cs_sync) begin
                    w_nx_state = IDLE;
                end
            end
            default: w_nx_state = IDLE;
        endcase
    end

    assign bus.miso      = (r_state == SHIFT) & r_tx_sr[BITS-1];
    assign bus.miso_oe   = ~w_cs_sync;
    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_spi_slave_duplex.sv
// tb/tb_spi_slave_duplex.sv - directed bench running all four SPI modes in parallel
module tb_spi_slave_duplex;
    localparam int          HALF = 6;
    localparam logic [31:0] RV   = 32'h4A23_0010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b1;
    logic        p = 1'b0;
    logic        mosi_a = 1'b0;
    logic        mosi_b = 1'b0;
    logic [31:0] tx_word = '0;

    always #5 clk = ~clk;

    spi_slave_duplex_if #(.BITS(32)) if0 ();
    spi_slave_duplex_if #(.BITS(32)) if1 ();
    spi_slave_duplex_if #(.BITS(32)) if2 ();
    spi_slave_duplex_if #(.BITS(32)) if3 ();

    // p is the mode-independent clock phase (0 = idle); CPOL=1 parts see it inverted.
    assign if0.cs_n = cs_n;  assign if0.sck = p;   assign if0.mosi = mosi_a;  assign if0.tx_data = tx_word;
    assign if1.cs_n = cs_n;  assign if1.sck = p;   assign if1.mosi = mosi_b;  assign if1.tx_data = tx_word;
    assign if2.cs_n = cs_n;  assign if2.sck = ~p;  assign if2.mosi = mosi_a;  assign if2.tx_data = tx_word;
    assign if3.cs_n = cs_n;  assign if3.sck = ~p;  assign if3.mosi = mosi_b;  assign if3.tx_data = tx_word;

    spi_slave_duplex #(.BITS(32), .CPOL(1'b0), .CPHA(1'b0), .TIMEOUT(16), .RESET_VALUE(RV)) u0 (.clk(clk), .reset(rst), .bus(if0));
    spi_slave_duplex #(.BITS(32), .CPOL(1'b0), .CPHA(1'b1), .TIMEOUT(16), .RESET_VALUE(RV)) u1 (.clk(clk), .reset(rst), .bus(if1));
    spi_slave_duplex #(.BITS(32), .CPOL(1'b1), .CPHA(1'b0), .TIMEOUT(16), .RESET_VALUE(RV)) u2 (.clk(clk), .reset(rst), .bus(if2));
    spi_slave_duplex #(.BITS(32), .CPOL(1'b1), .CPHA(1'b1), .TIMEOUT(16), .RESET_VALUE(RV)) u3 (.clk(clk), .reset(rst), .bus(if3));

    logic [31:0] rxd [4];
    logic        miso_w [4];
    logic        oe_w [4];
    logic        val_w [4];
    logic        err_w [4];

    assign rxd[0] = if0.rx_data;  assign miso_w[0] = if0.miso;  assign oe_w[0] = if0.miso_oe;  assign val_w[0] = if0.rx_valid;  assign err_w[0] = if0.frame_err;
    assign rxd[1] = if1.rx_data;  assign miso_w[1] = if1.miso;  assign oe_w[1] = if1.miso_oe;  assign val_w[1] = if1.rx_valid;  assign err_w[1] = if1.frame_err;
    assign rxd[2] = if2.rx_data;  assign miso_w[2] = if2.miso;  assign oe_w[2] = if2.miso_oe;  assign val_w[2] = if2.rx_valid;  assign err_w[2] = if2.frame_err;
    assign rxd[3] = if3.rx_data;  assign miso_w[3] = if3.miso;  assign oe_w[3] = if3.miso_oe;  assign val_w[3] = if3.rx_valid;  assign err_w[3] = if3.frame_err;

    int vcnt [4];
    int ecnt [4];

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (val_w[k] === 1'b1) vcnt[k] = vcnt[k] + 1;
            if (err_w[k] === 1'b1) ecnt[k] = ecnt[k] + 1;
        end
    end

    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] mrx [4];
    logic [31:0] first [4];
    int          vb [4];
    int          eb [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        for (int k = 0; k < 4; k++) begin
            vb[k] = vcnt[k];
            eb[k] = ecnt[k];
        end
    endtask

    // Master side: CPHA=0 parts get mosi_a (set before leading edge) and are read on the
    // leading edge; CPHA=1 parts get mosi_b (set on leading edge) and are read on trailing.
    task automatic frame_bits(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            mosi_a = w[31-i];
            clks(HALF);
            p = 1'b1;
            mosi_b = w[31-i];
            mrx[0] = {mrx[0][30:0], miso_w[0]};
            mrx[2] = {mrx[2][30:0], miso_w[2]};
            clks(HALF);
            p = 1'b0;
            mrx[1] = {mrx[1][30:0], miso_w[1]};
            mrx[3] = {mrx[3][30:0], miso_w[3]};
        end
    endtask

    task automatic exchange(input logic [31:0] tx, input logic [31:0] mw);
        tx_word = tx;
        snap();
        cs_n = 1'b0;
        clks(8);
        for (int k = 0; k < 4; k++) mrx[k] = '0;
        frame_bits(mw, 32);
        clks(HALF);
        cs_n = 1'b1;
        clks(10);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("xchg_rx_data_m%0d", k), rxd[k], mw);
            chk($sformatf("xchg_rx_valid_cnt_m%0d", k), vcnt[k] - vb[k], 32'd1);
            chk($sformatf("xchg_frame_err_cnt_m%0d", k), ecnt[k] - eb[k], 32'd0);
            chk($sformatf("xchg_miso_word_m%0d", k), mrx[k], tx);
        end
    endtask

    initial begin
        rst = 1'b1;
        clks(4);
        rst = 1'b0;
        clks(2);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset_rx_data_m%0d", k), rxd[k], RV);
            chk($sformatf("reset_miso_oe_m%0d", k), oe_w[k], 32'd0);
            chk($sformatf("reset_rx_valid_m%0d", k), val_w[k], 32'd0);
            chk($sformatf("reset_frame_err_m%0d", k), err_w[k], 32'd0);
        end

        // Deselect after 17 bits: abort, rx_data untouched.
        tx_word = 32'hFFFF_0000;
        snap();
        cs_n = 1'b0;
        clks(8);
        frame_bits(32'h1234_5678, 17);
        clks(HALF);
        cs_n = 1'b1;
        clks(10);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("abort_frame_err_cnt_m%0d", k), ecnt[k] - eb[k], 32'd1);
            chk($sformatf("abort_rx_valid_cnt_m%0d", k), vcnt[k] - vb[k], 32'd0);
            chk($sformatf("abort_rx_data_m%0d", k), rxd[k], RV);
        end

        exchange(32'hA5A5_0F0F, 32'h1234_5678);

        // Back-to-back frames with cs_n held low; tx reload picks up the new word.
        tx_word = 32'h1357_9BDF;
        snap();
        cs_n = 1'b0;
        clks(8);
        tx_word = 32'h2468_ACE0;
        for (int k = 0; k < 4; k++) mrx[k] = '0;
        frame_bits(32'hDEAD_BEEF, 32);
        for (int k = 0; k < 4; k++) first[k] = mrx[k];
        frame_bits(32'h0000_0001, 32);
        clks(HALF);
        cs_n = 1'b1;
        clks(10);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("b2b_miso_word1_m%0d", k), first[k], 32'h1357_9BDF);
            chk($sformatf("b2b_miso_word2_m%0d", k), mrx[k], 32'h2468_ACE0);
            chk($sformatf("b2b_rx_data_m%0d", k), rxd[k], 32'h0000_0001);
            chk($sformatf("b2b_rx_valid_cnt_m%0d", k), vcnt[k] - vb[k], 32'd2);
        end

        // Timeout after 5 bits, then stray edges while stalled are ignored.
        tx_word = 32'h0;
        snap();
        cs_n = 1'b0;
        clks(8);
        frame_bits(32'hFFFF_FFFF, 5);
        clks(24);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("tmo_frame_err_cnt_m%0d", k), ecnt[k] - eb[k], 32'd1);
        end
        frame_bits(32'hFFFF_FFFF, 32);
        clks(HALF);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("stall_rx_valid_cnt_m%0d", k), vcnt[k] - vb[k], 32'd0);
            chk($sformatf("stall_rx_data_m%0d", k), rxd[k], 32'h0000_0001);
        end
        cs_n = 1'b1;
        clks(10);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("stall_exit_frame_err_cnt_m%0d", k), ecnt[k] - eb[k], 32'd1);
        end
        exchange(32'h0BAD_F00D, 32'hC0FF_EE11);

        // Reset in the middle of a frame.
        tx_word = 32'hFFFF_FFFF;
        cs_n = 1'b0;
        clks(8);
        frame_bits(32'hAAAA_AAAA, 10);
        rst = 1'b1;
        clks(1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("midrst_rx_data_m%0d", k), rxd[k], RV);
            chk($sformatf("midrst_miso_m%0d", k), miso_w[k], 32'd0);
            chk($sformatf("midrst_miso_oe_m%0d", k), oe_w[k], 32'd0);
            chk($sformatf("midrst_rx_valid_m%0d", k), val_w[k], 32'd0);
            chk($sformatf("midrst_frame_err_m%0d", k), err_w[k], 32'd0);
        end
        rst = 1'b0;
        cs_n = 1'b1;
        clks(10);
        exchange(32'h5A5A_C3C3, 32'h8765_4321);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
